// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: result-source select, load/store widths
// and the memory-stage state enum.
package riscv_pkg;

    localparam logic [1:0] ResultSrcAlu = 2'b00;
    localparam logic [1:0] ResultSrcMem = 2'b01;
    localparam logic [1:0] ResultSrcPc4 = 2'b10;

    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    typedef enum logic {
        StIdle,
        StWaitR
    } mem_state_e;

endpackage

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. A bubble clears the write-back control and holds the data fields.
module mem_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ReadDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
        end else if (bubble) begin
            RdW        <= '0;
            RegWriteW  <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= ReadDataM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues loads/stores on a request/response bus, aligns store data,
// extends load data and stalls the front of the pipeline while an access is outstanding.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [1:0]  off;
    logic        mem_op;
    logic        misalign;
    logic        go;
    logic        req;
    logic        stall;
    logic        bus_err;
    logic [31:0] rdata_shift;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    assign off    = ALUResultM[1:0];
    assign mem_op = MemWriteM | (ResultSrcM == ResultSrcMem);
    assign go     = mem_op & ~misalign;

    always_comb begin
        misalign = 1'b0;
        unique case (Funct3M[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = off[0];
            default: misalign = (off != 2'b00);
        endcase
    end

    always_comb begin
        dmem_wdata = WriteDataM;
        dmem_be    = 4'b1111;
        unique case (Funct3M[1:0])
            2'b00: begin
                dmem_wdata = {4{WriteDataM[7:0]}};
                dmem_be    = 4'b0001 << off;
            end
            2'b01: begin
                dmem_wdata = {2{WriteDataM[15:0]}};
                dmem_be    = 4'b0011 << off;
            end
            default: ;
        endcase
    end

    assign dmem_addr = {ALUResultM[31:2], 2'b00};
    assign dmem_we   = MemWriteM;

    assign rdata_shift = dmem_rdata >> {off, 3'b000};
    assign lane_b      = rdata_shift[7:0];
    assign lane_h      = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        case (Funct3M)
            F3Byte:  load_data = {{24{lane_b[7]}}, lane_b};
            F3Half:  load_data = {{16{lane_h[15]}}, lane_h};
            F3ByteU: load_data = {24'b0, lane_b};
            F3HalfU: load_data = {16'b0, lane_h};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        bus_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    req   = 1'b1;
                    stall = 1'b1;
                    if (dmem_gnt) begin
                        state_d = StWaitR;
                        cnt_d   = '0;
                    end
                end
            end
            StWaitR: begin
                if (dmem_rvalid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    // Abandon the access; the write-back slot still retires, without a write.
                    bus_err = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req  = req & ~reset;
    assign StallM    = stall & go & ~reset;
    assign BusErrM   = bus_err & ~reset;
    assign MisalignM = mem_op & misalign & ~reset;

    mem_wb u_mem_wb (
        .clk        (clk),
        .reset      (reset),
        .bubble     (StallM),
        .ALUResultM (ALUResultM),
        .ReadDataM  (load_data),
        .PCPlus4M   (PCPlus4M),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM & ~(mem_op & misalign) & ~bus_err),
        .ResultSrcM (ResultSrcM),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a byte-level memory model predicts each retirement,
// a monitor compares every MEM/WB update against the queue.
module tb_memory_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, MisalignM, BusErrM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    memory_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
    } instr_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd_data;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        bit          chk_data;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem[int unsigned];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] rdb(input int unsigned a);
        if (mem.exists(a)) return mem[a];
        return 8'(a * 37 + 11);
    endfunction

    function automatic logic [31:0] rdw(input int unsigned a);
        int unsigned b;
        b = a & ~32'd3;
        return {rdb(b + 3), rdb(b + 2), rdb(b + 1), rdb(b)};
    endfunction

    // Monitor: every edge either resets, inserts a bubble, or retires the head of the queue.
    initial begin
        logic st, rs;
        exp_t e;
        forever begin
            @(posedge clk);
            st = StallM;
            rs = reset;
            #1;
            if (rs) begin
                chk("reset_w", {31'b0, |{ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW,
                                         ResultSrcW}}, 32'd0);
            end else if (st) begin
                chk("bubble", {26'b0, RdW, RegWriteW}, 32'd0);
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got retirement, expected none (t=%0t)",
                         $time);
            end else begin
                e = sb_q.pop_front();
                chk("alu_w", ALUResultW, e.alu);
                chk("pc4_w", PCPlus4W, e.pc4);
                chk("rd_w", {27'b0, RdW}, {27'b0, e.rd});
                chk("regwrite_w", {31'b0, RegWriteW}, {31'b0, e.rw});
                chk("resultsrc_w", {30'b0, ResultSrcW}, {30'b0, e.rs});
                if (e.chk_data) chk("readdata_w", ReadDataW, e.rd_data);
            end
        end
    end

    // Presents one instruction starting at a negedge and plays the bus responder for it.
    task automatic run(input instr_t in, input int g, input int r, input bit tmo,
                       input bit rst_mid, input bit stale);
        bit          memop, mis;
        int unsigned a, n, off, stalls, exp_stalls;
        logic [31:0] ld, wd;
        logic [3:0]  be;
        exp_t        e;
        a     = in.addr;
        memop = in.mw || (in.rs == 2'b01);
        n     = (in.f3[1:0] == 2'b00) ? 1 : (in.f3[1:0] == 2'b01) ? 2 : 4;
        off   = a % 4;
        mis   = memop && (a % n != 0);
        ld    = '0;
        for (int i = 0; i < int'(n); i++) ld = ld | (32'(rdb(a + i)) << (8 * i));
        if (!in.f3[2] && n < 4 && ld[8 * n - 1]) ld = ld - (32'd1 << (8 * n));
        be = '0;
        if (!mis) for (int i = 0; i < int'(n); i++) be[off + i] = 1'b1;
        wd = (n == 1) ? {4{in.wdata[7:0]}} : (n == 2) ? {2{in.wdata[15:0]}} : in.wdata;

        ALUResultM = in.addr; WriteDataM = in.wdata; PCPlus4M = in.pc4; RdM = in.rd;
        RegWriteM = in.rw; MemWriteM = in.mw; ResultSrcM = in.rs; Funct3M = in.f3;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

        e.alu = in.addr; e.pc4 = in.pc4; e.rd = in.rd; e.rs = in.rs; e.rd_data = ld;
        if (!memop || mis) begin
            e.rw = in.rw && !mis; e.chk_data = 1'b0;
            sb_q.push_back(e);
            dmem_rvalid = stale;
            dmem_rdata  = $urandom;
            #1;
            chk("stall_nomem", {31'b0, StallM}, 32'd0);
            chk("req_nomem", {31'b0, dmem_req}, 32'd0);
            chk("misalign", {31'b0, MisalignM}, {31'b0, mis});
            @(negedge clk);
            dmem_rvalid = 1'b0;
            return;
        end

        if (!rst_mid) begin
            e.rw = in.rw && !tmo; e.chk_data = !in.mw && !tmo;
            sb_q.push_back(e);
        end
        stalls     = 0;
        exp_stalls = tmo ? g + TIMEOUT : g + 1 + r;
        for (int c = 0; c <= g; c++) begin
            dmem_gnt = (c == g);
            #1;
            if (StallM) stalls++;
            if (c == g) begin
                chk("req", {31'b0, dmem_req}, 32'd1);
                chk("addr", dmem_addr, in.addr & ~32'd3);
                chk("we", {31'b0, dmem_we}, {31'b0, in.mw});
                chk("be", {28'b0, dmem_be}, {28'b0, be});
                if (in.mw) chk("wdata", dmem_wdata, wd);
            end
            @(negedge clk);
            dmem_gnt = 1'b0;
        end
        if (rst_mid) begin
            reset = 1'b1;
            #1;
            chk("stall_in_reset", {31'b0, StallM}, 32'd0);
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        for (int k = 0; ; k++) begin
            bit last;
            last        = tmo ? (k == int'(TIMEOUT) - 1) : (k == r);
            dmem_rvalid = !tmo && (k == r);
            dmem_rdata  = in.mw ? $urandom : rdw(a);
            #1;
            if (StallM) stalls++;
            if (tmo && last) chk("buserr", {31'b0, BusErrM}, 32'd1);
            @(negedge clk);
            dmem_rvalid = 1'b0;
            if (last) break;
        end
        chk("stall_cycles", stalls, exp_stalls);
        if (in.mw && !tmo) for (int i = 0; i < int'(n); i++) mem[a + i] = in.wdata[8 * i +: 8];
    endtask

    function automatic instr_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic mw, input logic [1:0] rs, input logic [2:0] f3);
        instr_t t;
        t.addr = addr; t.wdata = wdata; t.mw = mw; t.rs = rs; t.f3 = f3;
        t.rw   = !mw;
        t.pc4  = $urandom;
        t.rd   = 5'($urandom_range(1, 31));
        return t;
    endfunction

    initial begin
        instr_t t;
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0; RegWriteM = 1'b0;
        MemWriteM = 1'b0; ResultSrcM = '0; Funct3M = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Outputs stay quiet while reset is held, even with memory ops presented.
        @(negedge clk);
        ALUResultM = 32'h40; MemWriteM = 1'b1; Funct3M = 3'b010; dmem_gnt = 1'b1;
        #1;
        chk("reset_stall", {31'b0, StallM}, 32'd0);
        chk("reset_req", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        ALUResultM = 32'h41; MemWriteM = 1'b0; ResultSrcM = 2'b01;
        #1;
        chk("reset_misalign", {31'b0, MisalignM}, 32'd0);
        @(negedge clk);
        dmem_gnt = 1'b0;
        reset = 1'b0;

        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        run(mk(32'h100, 0, 1'b0, 2'b01, 3'b010), 0, 0, 0, 0, 0);
        mem[32'h103] = 8'h80;
        run(mk(32'h103, 0, 1'b0, 2'b01, 3'b000), 0, 1, 0, 0, 0);
        run(mk(32'h103, 0, 1'b0, 2'b01, 3'b100), 1, 0, 0, 0, 0);
        run(mk(32'h202, 32'h1234, 1'b1, 2'b00, 3'b001), 3, 0, 0, 0, 0);
        run(mk(32'h200, 0, 1'b0, 2'b01, 3'b010), 0, 0, 0, 0, 0);
        run(mk(32'h101, 0, 1'b0, 2'b01, 3'b010), 0, 0, 0, 0, 0);
        run(mk(32'h104, 0, 1'b0, 2'b01, 3'b010), 1, 0, 1, 0, 0);
        run(mk(32'h55, 0, 1'b0, 2'b00, 3'b000), 0, 0, 0, 0, 1);
        run(mk(32'h108, 0, 1'b0, 2'b01, 3'b101), 0, 2, 0, 1, 0);
        run(mk(32'h102, 0, 1'b0, 2'b01, 3'b001), 0, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            int          kind;
            logic [2:0]  f3;
            int unsigned n, a;
            bit          tmo, rm;
            kind = $urandom_range(0, 9);
            a    = $urandom_range(0, 63);
            if (kind < 3) begin
                t = mk($urandom, $urandom, 1'b0, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                       3'($urandom));
                t.rw = 1'($urandom);
                run(t, 0, 0, 0, 0, 1'($urandom));
                continue;
            end
            case ($urandom_range(0, 4))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            if (kind >= 7 && f3[2]) f3[2] = 1'b0;
            n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            if ($urandom_range(0, 4) != 0) a = a & ~(n - 1);
            t   = (kind >= 7) ? mk(a, $urandom, 1'b1, 2'b00, f3)
                              : mk(a, 0, 1'b0, 2'b01, f3);
            tmo = ($urandom_range(0, 19) == 0);
            rm  = !tmo && ($urandom_range(0, 29) == 0);
            run(t, $urandom_range(0, 3), $urandom_range(0, 3), tmo, rm, 0);
        end

        chk("queue_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory (M) stage of the 5-stage RV32I pipeline. It sits between the EX/MEM register and writeback. It performs the load/store for the instruction in M over a two-phase request/response data-memory bus and aligns store data and byte enables. It sign- or zero-extends load data, stalls the front of the pipeline while an access is outstanding, and owns the MEM/WB pipeline register.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for a response before the access is abandoned.

Ports:
- clk  in  1  system clock; one clock domain; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUResultM  in  32  effective address, or ALU result for non-memory instructions.
- WriteDataM  in  32  store data (rs2).
- PCPlus4M  in  32  link value.
- RdM  in  5  destination register.
- RegWriteM, MemWriteM  in  1  control from EX/MEM.
- ResultSrcM  in  2  00 = ALU, 01 = memory, 10 = PC+4.
- Funct3M  in  3  load/store width: 000 = b, 001 = h, 010 = w, 100 = bu, 101 = hu.
- dmem_req, dmem_we  out  1  request valid / write.
- dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  response valid.
- dmem_rdata  in  32  read data.
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- MisalignM, BusErrM  out  1  one-cycle error pulses.
- ALUResultW, ReadDataW, PCPlus4W  out  32  MEM/WB register.
- RdW  out  5  MEM/WB register.
- RegWriteW  out  1  MEM/WB register.
- ResultSrcW  out  2  MEM/WB register.

## Operation
- Memory op in M: MemWriteM = 1, or ResultSrcM = 01.
- FSM states are IDLE and WAIT_R.
  - IDLE, memory op, aligned: dmem_req = 1, with address, we, be, wdata driven combinationally from the M inputs.
    - gnt = 0: stay in IDLE.
    - gnt = 1: go to WAIT_R.
  - WAIT_R: dmem_req = 0; a saturating wait counter counts cycles.
    - rvalid = 1: complete and return to IDLE.
    - Counter reaches TIMEOUT-1 without rvalid: pulse BusErrM, complete with RegWriteW = 0, return to IDLE.
- StallM = memory op & aligned & (IDLE & !gnt | IDLE & gnt | WAIT_R & !rvalid). It is deasserted in the completion cycle.
- While StallM = 1, MEM/WB loads a bubble: RegWriteW = 0, RdW = 0; the other W fields hold.
- On completion, or for a non-memory instruction, MEM/WB loads the M fields, and ReadDataW gets the extended load data.
- Alignment:
  - Half-word access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - A misaligned access issues no request and raises no stall; MisalignM pulses and MEM/WB loads with RegWriteW = 0.
- Store data and byte enables:
  - sb: wdata = {4{b}}, be = 0001 << addr[1:0].
  - sh: wdata = {2{h}}, be = 0011 << addr[1:0].
  - sw: be = 1111.
- Load data:
  - Byte/half lane is selected by addr[1:0].
  - b/h are sign-extended; bu/hu are zero-extended.
- An rvalid arriving in IDLE (stale, after a timeout or reset) is ignored.

## Timing
- Reset values: state = IDLE, counter = 0; all W outputs 0; dmem_req = 0.
- Reset gating: StallM, MisalignM, BusErrM are forced 0 while reset = 1.
- Reset mid-access: the outstanding access is dropped; no completion is written.
- Minimum memory-op latency is 2 cycles, with 1 stall cycle: gnt in cycle N, rvalid in N+1.
- Each extra cycle of gnt or rvalid delay adds one stall cycle.
- Non-memory instructions pass through with 1-cycle latency and no stall.
- Writes also wait for rvalid as their write acknowledge.
- M inputs must remain stable while StallM = 1; EX/MEM honours the stall.

## Structure
- riscv_pkg holds:
  - ResultSrc encodings.
  - Funct3 load/store constants.
  - The memory-stage state enum.
- Sub-module mem_wb: the MEM/WB register with a synchronous reset and a bubble input, a companion to ex_mem.
- Alignment, extension and FSM logic stay in memory_stage.

## Test plan
- lw at 0x100, gnt in the first cycle, rvalid next cycle with 0xDEADBEEF -> StallM high for exactly 1 cycle; ReadDataW = 0xDEADBEEF, RegWriteW = 1.
- lb at 0x103, rdata = 0x80xxxxxx -> ReadDataW = 0xFFFFFF80. Same access as lbu -> ReadDataW = 0x00000080.
- sh 0x1234 at 0x202 -> dmem_be = 1100, dmem_wdata = 0x12341234, dmem_we = 1. gnt delayed 3 cycles -> 4 stall cycles total.
- lw at 0x101 -> MisalignM pulse, no dmem_req, no stall, RegWriteW = 0.
- gnt, then no rvalid for TIMEOUT cycles -> BusErrM pulse and return to IDLE. A late rvalid afterwards is ignored.
- reset asserted in WAIT_R -> all W outputs 0 next cycle, state IDLE, no write to RdW.
